// File: rtl/hamming_uart_rx_pkg.sv
// Shared definitions for the Hamming(8,4) UART link: FSM encodings,
// default rates and codeword bit positions. The transmitter imports it too.
package hamming_uart_rx_pkg;

  localparam int DEF_CLK_SPEED = 100_000_000;
  localparam int DEF_BAUD_RATE = 115_200;

  // Codeword layout {p5,d3,d2,d1,p4,d0,p2,p1}; bit[k] is Hamming position k+1
  localparam int P1 = 0;
  localparam int P2 = 1;
  localparam int D0 = 2;
  localparam int P4 = 3;
  localparam int D1 = 4;
  localparam int D2 = 5;
  localparam int D3 = 6;
  localparam int P5 = 7;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3,
    S_DECODE = 3'd4
  } rx_state_t;

  // Even parity over a whole codeword (the p5 check)
  function automatic logic parity8(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/hamming_uart_rx_if.sv
// Receiver-side bundle: serial line in, decoded nibble and status out.
// Handshake: valid is a single-cycle pulse; data_out, raw_byte, syndrome,
// sec, ded and frame_err change only in the cycle valid is high and hold
// their values otherwise. There is no ready: the consumer must take the
// result in the valid cycle. state is a debug view of the receive FSM.
interface hamming_uart_rx_if;
  import hamming_uart_rx_pkg::*;

  logic       rx;
  logic [3:0] data_out;
  logic [7:0] raw_byte;
  logic [2:0] syndrome;
  logic       valid;
  logic       sec;
  logic       ded;
  logic       frame_err;
  rx_state_t  state;

  modport master (
    input  rx,
    output data_out, raw_byte, syndrome, valid, sec, ded, frame_err, state
  );

  modport slave (
    output rx,
    input  data_out, raw_byte, syndrome, valid, sec, ded, frame_err, state
  );
endinterface

// File: rtl/hamming_secded_decode.sv
// Combinational Hamming(8,4) SECDED decoder. Corrects any single-bit error,
// flags double errors. Also used by the loopback checker.
module hamming_secded_decode
  import hamming_uart_rx_pkg::*;
(
  input  logic [7:0] code,
  output logic [3:0] nibble,
  output logic [2:0] syndrome,
  output logic       sec,
  output logic       ded
);

  logic       s1;
  logic       s2;
  logic       s4;
  logic       overall;
  logic [7:0] fixed;

  // Syndrome, overall parity and single-bit correction
  always_comb begin
    s1       = code[P1] ^ code[D0] ^ code[D1] ^ code[D3];
    s2       = code[P2] ^ code[D0] ^ code[D2] ^ code[D3];
    s4       = code[P4] ^ code[D1] ^ code[D2] ^ code[D3];
    overall  = parity8(code);
    syndrome = {s4, s2, s1};
    fixed    = code;
    sec      = 1'b0;
    ded      = 1'b0;
    if (overall) begin
      // Odd overall parity: single error. Syndrome 0 means p5 itself flipped.
      sec = 1'b1;
      if (syndrome != 3'd0) begin
        fixed[syndrome - 3'd1] = ~code[syndrome - 3'd1];
      end
    end else if (syndrome != 3'd0) begin
      // Even parity with a nonzero syndrome: two bits wrong, leave data raw
      ded = 1'b1;
    end
    nibble = {fixed[D3], fixed[D2], fixed[D1], fixed[D0]};
  end

endmodule

// File: rtl/hamming_uart_rx.sv
// 8N1 UART receiver feeding a Hamming(8,4) SECDED decoder. Holds the rx
// synchronizer, receive FSM, bit counters, shift register and result registers.
module hamming_uart_rx
  import hamming_uart_rx_pkg::*;
#(
  parameter int CLK_SPEED = DEF_CLK_SPEED,
  parameter int BAUD_RATE = DEF_BAUD_RATE
) (
  input logic clk,
  input logic rst,
  hamming_uart_rx_if.master bus
);

  localparam int CLKS_PER_BIT = CLK_SPEED / BAUD_RATE;
  localparam int CTR_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CTR_W-1:0] BIT_END  = CTR_W'(CLKS_PER_BIT - 1);
  localparam logic [CTR_W-1:0] HALF_END = CTR_W'(CLKS_PER_BIT / 2 - 1);

  rx_state_t        state;
  logic [CTR_W-1:0] clk_ctr;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             stop_err;

  logic             rx_meta;
  logic             rx_s;
  logic             rx_prev;

  logic [3:0]       dec_nibble;
  logic [2:0]       dec_syndrome;
  logic             dec_sec;
  logic             dec_ded;

  assign bus.state = state;

  // Two-flop synchronizer; the history bit is frozen during DECODE so a
  // start edge arriving in that cycle is still seen once back in IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= bus.rx;
      rx_s    <= rx_meta;
      if (state != S_DECODE) begin
        rx_prev <= rx_s;
      end
    end
  end

  hamming_secded_decode u_decode (
    .code     (shreg),
    .nibble   (dec_nibble),
    .syndrome (dec_syndrome),
    .sec      (dec_sec),
    .ded      (dec_ded)
  );

  // Receive FSM with registered results and the one-cycle valid pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      clk_ctr       <= '0;
      bit_idx       <= '0;
      shreg         <= '0;
      stop_err      <= 1'b0;
      bus.data_out  <= '0;
      bus.raw_byte  <= '0;
      bus.syndrome  <= '0;
      bus.valid     <= 1'b0;
      bus.sec       <= 1'b0;
      bus.ded       <= 1'b0;
      bus.frame_err <= 1'b0;
    end else begin
      bus.valid <= 1'b0;
      case (state)
        S_IDLE: begin
          clk_ctr <= '0;
          bit_idx <= '0;
          if (rx_prev && !rx_s) begin
            state <= S_START;
          end
        end
        S_START: begin
          if (clk_ctr == HALF_END) begin
            clk_ctr <= '0;
            // A line back high at mid start bit was only a glitch
            state   <= rx_s ? S_IDLE : S_DATA;
          end else begin
            clk_ctr <= clk_ctr + CTR_W'(1);
          end
        end
        S_DATA: begin
          if (clk_ctr == BIT_END) begin
            clk_ctr        <= '0;
            shreg[bit_idx] <= rx_s;
            bit_idx        <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= S_STOP;
            end
          end else begin
            clk_ctr <= clk_ctr + CTR_W'(1);
          end
        end
        S_STOP: begin
          if (clk_ctr == BIT_END) begin
            clk_ctr  <= '0;
            stop_err <= ~rx_s;
            state    <= S_DECODE;
          end else begin
            clk_ctr <= clk_ctr + CTR_W'(1);
          end
        end
        S_DECODE: begin
          bus.data_out  <= dec_nibble;
          bus.raw_byte  <= shreg;
          bus.syndrome  <= dec_syndrome;
          bus.sec       <= dec_sec;
          bus.ded       <= dec_ded;
          bus.frame_err <= stop_err;
          bus.valid     <= 1'b1;
          state         <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hamming_uart_rx.sv
// Bench for hamming_uart_rx: directed frames, error injection, glitch and
// reset abort, exhaustive single-bit flips and randomized traffic.
module tb_hamming_uart_rx;
  import hamming_uart_rx_pkg::*;

  localparam int CLK_SPEED = 1_600_000;
  localparam int BAUD_RATE = 100_000;
  localparam int CPB       = CLK_SPEED / BAUD_RATE;
  localparam int W         = 18;  // {frame_err, ded, sec, syndrome, raw, nibble}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hamming_uart_rx_if bus ();

  hamming_uart_rx #(
    .CLK_SPEED (CLK_SPEED),
    .BAUD_RATE (BAUD_RATE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int valid_count = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] held = '0;

  // ---------------- reference model ----------------
  // Encoder built from the Hamming definition: parity bit at position p
  // covers every position whose index has bit p set.
  function automatic logic [7:0] encode(input logic [3:0] n);
    logic [7:0] c;
    logic       par;
    c    = '0;
    c[2] = n[0];
    c[4] = n[1];
    c[5] = n[2];
    c[6] = n[3];
    for (int p = 1; p <= 4; p = p * 2) begin
      par = 1'b0;
      for (int j = 1; j <= 7; j++) begin
        if ((j & p) != 0 && j != p) par = par ^ c[j-1];
      end
      c[p-1] = par;
    end
    c[7] = ^c[6:0];
    return c;
  endfunction

  // Syndrome as the XOR of the positions of all set bits
  function automatic logic [W-1:0] model(input logic [7:0] b, input logic stop_bit);
    int         syn;
    logic       odd;
    logic       s_c;
    logic       d_d;
    logic [7:0] c;
    syn = 0;
    for (int k = 0; k < 7; k++) begin
      if (b[k]) syn = syn ^ (k + 1);
    end
    odd = ^b;
    c   = b;
    s_c = 1'b0;
    d_d = 1'b0;
    if (odd) begin
      s_c = 1'b1;
      if (syn != 0) c[syn-1] = ~c[syn-1];
    end else if (syn != 0) begin
      d_d = 1'b1;
    end
    return {~stop_bit, d_d, s_c, 3'(syn), b, c[6], c[5], c[4], c[2]};
  endfunction

  function automatic logic [W-1:0] actual();
    return {bus.frame_err, bus.ded, bus.sec, bus.syndrome, bus.raw_byte, bus.data_out};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every cycle out of reset: a valid pulse must match the next expected
  // frame; otherwise outputs must hold the last result.
  always @(negedge clk) begin
    if (rst) begin
      held = '0;
    end else if (bus.valid === 1'b1) begin
      valid_count++;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_valid: got valid=1 expected valid=0 (t=%0t)", $time);
      end else begin
        held = exp_q.pop_front();
        check("frame", 32'(actual()), 32'(held));
      end
    end else begin
      check("hold", {13'd0, bus.valid, actual()}, {14'd0, held});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic bit_time();
    repeat (CPB) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    exp_q.push_back(model(b, stop_bit));
    bus.rx = 1'b0;
    bit_time();
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      bit_time();
    end
    bus.rx = stop_bit;
    bit_time();
    bus.rx = 1'b1;
    if (!stop_bit) bit_time();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 4 * CPB) begin
      @(posedge clk);
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] m;
    logic [7:0]   cw;
    logic [7:0]   err;
    int           snap;
    int           nflip;
    logic         stop_bit;

    bus.rx = 1'b1;
    rst    = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("reset_outs", {13'd0, bus.valid, actual()}, 0);
    @(posedge clk);
    rst = 1'b0;
    bit_time();

    // Hand-computed pins on the model
    check("pin_encode_B", encode(4'hB), 8'h55);
    check("pin_clean",    model(8'h55, 1'b1), {3'b000, 3'd0, 8'h55, 4'hB});
    check("pin_d0_flip",  model(8'h51, 1'b1), {3'b001, 3'd3, 8'h51, 4'hB});
    check("pin_p5_flip",  model(8'hD5, 1'b1), {3'b001, 3'd0, 8'hD5, 4'hB});
    check("pin_double",   model(8'h50, 1'b1), {3'b010, 3'd2, 8'h50, 4'hA});
    check("pin_frame",    model(8'h55, 1'b0), {3'b100, 3'd0, 8'h55, 4'hB});

    // Directed frames
    send_frame(8'h55, 1'b1); bit_time();
    send_frame(8'h51, 1'b1); bit_time();
    send_frame(8'hD5, 1'b1); bit_time();
    send_frame(8'h50, 1'b1); bit_time();
    send_frame(8'h55, 1'b0);
    drain();

    // Short low glitch must not start a frame
    snap = valid_count;
    bus.rx = 1'b0;
    repeat (CPB * 3 / 10) @(posedge clk);
    bus.rx = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    check("glitch_no_valid", valid_count, snap);

    // Reset in the middle of the data bits aborts the frame
    snap = valid_count;
    bus.rx = 1'b0; bit_time();
    bus.rx = 1'b1; bit_time();
    bus.rx = 1'b0; bit_time();
    bus.rx = 1'b1; repeat (CPB / 2) @(posedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_mid_outs", {13'd0, bus.valid, actual()}, 0);
    @(posedge clk);
    rst = 1'b0;
    repeat (3 * CPB) @(posedge clk);
    check("abort_no_valid", valid_count, snap);
    send_frame(8'h55, 1'b1);
    drain();

    // Every nibble with every single-bit flip, back to back
    for (int n = 0; n < 16; n++) begin
      for (int k = 0; k < 8; k++) begin
        cw = encode(4'(n)) ^ (8'h01 << k);
        m  = model(cw, 1'b1);
        if (k == 0) check("exh_model", {m[15], m[3:0]}, {1'b1, 4'(n)});
        send_frame(cw, 1'b1);
      end
    end
    drain();

    // Random traffic: 0..2 flipped bits, occasional bad stop bit, random gaps
    for (int i = 0; i < 40; i++) begin
      cw    = encode(4'($urandom_range(0, 15)));
      nflip = $urandom_range(0, 2);
      err   = '0;
      while ($countones(err) < nflip) err[$urandom_range(0, 7)] = 1'b1;
      stop_bit = ($urandom_range(0, 7) != 0);
      send_frame(cw ^ err, stop_bit);
      repeat ($urandom_range(0, CPB)) @(posedge clk);
    end
    drain();
    bit_time();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Overall time limit
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish by 2000000");
    $fatal(1, "watchdog expired");
  end

endmodule
